dff_jkff_bank: RTL and testbench



---
 rtl/dff_jkff_pkg.sv | 13 +
 rtl/dff_jkff_bank_jk_cell.sv | 42 ++++
 rtl/dff_jkff_bank.sv | 51 +++++
 tb/tb_dff_jkff_bank.sv | 124 ++++++++++++
 4 files changed

// File: rtl/dff_jkff_pkg.sv
// Shared constants for the D/JK register bank: JK input encodings and reset values.
package dff_jkff_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam logic RST_Q    = 1'b0;
    localparam logic RST_Q_JK = 1'b0;
    localparam logic RST_QN   = 1'b1;

endpackage

// File: rtl/dff_jkff_bank_jk_cell.sv
// Single-bit JK element; q and qn are both registered so qn never glitches against q.
module jk_cell
    import dff_jkff_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_j,
    input  logic i_k,
    output logic o_q,
    output logic o_qn
);

    logic r_q;
    logic r_qn;
    logic w_nxt;

    always_comb begin
        w_nxt = r_q;
        case ({i_j, i_k})
            JK_HOLD: w_nxt = r_q;
            JK_CLR:  w_nxt = 1'b0;
            JK_SET:  w_nxt = 1'b1;
            JK_TGL:  w_nxt = ~r_q;
            default: w_nxt = 1'bx;  // unknown j/k poisons only this bit
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q  <= RST_Q_JK;
            r_qn <= RST_QN;
        end else if (i_en) begin
            r_q  <= w_nxt;
            r_qn <= ~w_nxt;
        end
    end

    assign o_q  = r_q;
    assign o_qn = r_qn;

endmodule

// File: rtl/dff_jkff_bank.sv
// WIDTH-bit D register plus WIDTH-bit JK register on one clock and sync reset.
// Define FF_CE_EN to add a clock-enable port (ce) gating both registers.
module dff_jkff_bank
    import dff_jkff_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef FF_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q_jk,
    output logic [WIDTH-1:0] qn_jk
);

    logic             w_en;
    logic [WIDTH-1:0] r_q;

`ifdef FF_CE_EN
    assign w_en = ce;
`else
    assign w_en = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_q <= {WIDTH{RST_Q}};
        else if (w_en)
            r_q <= d;
    end

    assign q = r_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_jk
        jk_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_en),
            .i_j  (j[g]),
            .i_k  (k[g]),
            .o_q  (q_jk[g]),
            .o_qn (qn_jk[g])
        );
    end

endmodule

// File: tb/tb_dff_jkff_bank.sv
// Directed bench for dff_jkff_bank (WIDTH=4); ce checks build only with FF_CE_EN.
module tb_dff_jkff_bank;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clk_run = 1'b1;
    logic         rst = 1'b1;
    logic         ce = 1'b1;
    logic [W-1:0] d = '0, j = '0, k = '0;
    logic [W-1:0] q, q_jk, qn_jk;

    int n_cmp = 0;
    int n_bad = 0;

    dff_jkff_bank #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef FF_CE_EN
        .ce    (ce),
`endif
        .d     (d),
        .q     (q),
        .j     (j),
        .k     (k),
        .q_jk  (q_jk),
        .qn_jk (qn_jk)
    );

    // Gated clock so the bench can hold clk at a constant level.
    always #5 clk = clk_run ? ~clk : clk;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_jk(input string tag, input logic [W-1:0] exp);
        chk({tag, ".q_jk"}, q_jk, exp);
        chk({tag, ".qn_jk"}, qn_jk, ~exp);
    endtask

    initial begin
        // Reset dominates d=1s and j=1,k=0
        rst = 1'b1; d = '1; j = '1; k = '0;
        step();
        chk("rst.q", q, '0);
        chk_jk("rst", '0);

        // D capture
        rst = 1'b0; d = '0; j = '0; k = '0;
        step();
        chk("d0", q, 4'b0000);
        d = '1;
        step();
        chk("d1", q, 4'b1111);
        d = 4'b1001;
        step();
        chk("d_pat", q, 4'b1001);
        d = '1;
        step();
        chk("d_ones", q, 4'b1111);

        // Static clock: no rising edge, inputs change, state must hold
        clk_run = 1'b0;
        d = '0; j = '1; k = '0;
        #30;
        chk("static.q", q, 4'b1111);
        chk_jk("static", '0);
        j = '0;
        clk_run = 1'b1;

        // JK sequence
        j = '1; k = '0; step(); chk_jk("set", '1);
        j = '0; k = '1; step(); chk_jk("clr", '0);
        j = '0; k = '0; step(); chk_jk("hold", '0);
        j = '1; k = '1;
        step(); chk_jk("tgl1", '1);
        step(); chk_jk("tgl2", '0);
        step(); chk_jk("tgl3", '1);
        step(); chk_jk("tgl4", '0);

        // Reset mid-toggle
        step(); chk_jk("mt_pre", '1);
        rst = 1'b1;
        step(); chk_jk("mt_rst1", '0);
        step(); chk_jk("mt_rst2", '0);
        chk("mt_rst.q", q, '0);
        rst = 1'b0;
        step(); chk_jk("mt_resume", '1);

        // Bit independence: 0101 then j=1010,k=0110 -> set,clr,tgl,hold
        j = 4'b0101; k = 4'b1010;
        step(); chk_jk("ind_pre", 4'b0101);
        j = 4'b1010; k = 4'b0110;
        step(); chk_jk("ind", 4'b1011);

`ifdef FF_CE_EN
        d = 4'b0110; j = '0; k = '0;
        step(); chk("ce_pre.q", q, 4'b0110);
        ce = 1'b0; d = '1; j = '1; k = '0;
        step();
        chk("ce0.q", q, 4'b0110);
        chk_jk("ce0", 4'b1011);
        rst = 1'b1;
        step();
        chk("ce0_rst.q", q, '0);
        chk_jk("ce0_rst", '0);
        rst = 1'b0; ce = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
